alu_pipe: RTL and testbench
===========================

ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits; legal values 4..32.
REQ-002 clk  input  1  rising-edge clock; sole clock of the block.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-004 in_valid  input  1  operation request valid.
REQ-005 in_ready  output  1  block can accept a request this cycle.
REQ-006 op  input  3  opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR (logical), 111 MUL.
REQ-007 opa  input  WIDTH  operand A.
REQ-008 opb  input  WIDTH  operand B; also the shift amount for SHL/SHR.
REQ-009 out_valid  output  1  result registers hold a completed operation.
REQ-010 out_ready  input  1  consumer accepts the result this cycle.
REQ-011 result  output  WIDTH  operation result.
REQ-012 carry  output  1  carry, borrow or overflow flag.
REQ-013 zero  output  1  result equals zero.
REQ-014 err  output  1  opcode not supported in this build.

Function
REQ-015 A request is accepted on a rising clk edge where in_valid and in_ready are both 1; op/opa/opb are captured at that edge only.
REQ-016 The FSM has three states:
- IDLE: no result held.
- MUL: iterative multiply in progress.
- HOLD: result valid.
REQ-017 in_ready is 1 in IDLE, and in HOLD when out_ready is 1; it is 0 in MUL.
REQ-018 Ops other than MUL go to HOLD at the accepting edge; out_valid is 1 the cycle after acceptance (latency 1).
REQ-019 Back-to-back: in HOLD with out_ready=1 and in_valid=1, the new result replaces the old one at the same edge; sustained throughput is 1 operation per cycle.
REQ-020 In HOLD with out_ready=1 and no new request, the FSM returns to IDLE and out_valid falls.
REQ-021 When out_valid=1 and out_ready=0, result, carry, zero and err hold stable.
REQ-022 ADD: result = (opa+opb) mod 2^WIDTH; carry = carry-out.
REQ-023 SUB: result = (opa-opb) mod 2^WIDTH; carry = 1 when opa < opb (unsigned borrow).
REQ-024 AND/OR/XOR: bitwise result; carry = 0.
REQ-025 SHL/SHR: shift opa by the full unsigned value of opb; a shift amount >= WIDTH yields 0; carry = 0.
REQ-026 zero = 1 exactly when result is all zeros, for every op.
REQ-027 err = 0 for every supported op.

Reset
REQ-028 While reset=1 at a clk edge, the FSM goes to IDLE and all of the following are 0 the next cycle:
- out_valid
- result
- carry
- zero
- err
- the multiply counter
REQ-029 Reset has priority over every other event, including an acceptance at the same edge.
REQ-030 Reset during MUL or HOLD discards the in-flight transaction; no result is delivered.
REQ-031 in_ready is 1 in the first cycle after reset is released.

Configuration
REQ-032 Macro ALU_MUL_EN compiles the iterative multiplier in or out.
REQ-033 With ALU_MUL_EN defined, MUL is handled as follows:
- Acceptance enters state MUL.
- One shift-add step is performed per cycle for exactly WIDTH cycles, then the FSM goes to HOLD.
- out_valid rises WIDTH+1 cycles after acceptance.
- result = low WIDTH bits of opa*opb (unsigned).
- carry = 1 when the upper WIDTH product bits are nonzero.
REQ-034 Without ALU_MUL_EN, the MUL state and multiplier logic do not exist; MUL completes with latency 1, result=0, carry=0, zero=1, err=1.

Verification
REQ-035 ADD with opa=8'hFF, opb=8'h01 (WIDTH=8) -> out_valid 1 cycle after acceptance, result=8'h00, carry=1, zero=1, err=0.
REQ-036 SUB with opa=8'h03, opb=8'h05, then SHL with opa=8'h81, opb=8'h09 -> results 8'hFE carry=1, then 8'h00 zero=1.
REQ-037 With ALU_MUL_EN, MUL 8'h0F*8'h11 -> in_ready=0 for 8 cycles, out_valid at cycle 9, result=8'hFF, carry=0; MUL 8'h10*8'h10 -> result=8'h00, carry=1, zero=1.
REQ-038 Hold out_ready=0 for 3 cycles after an ADD completes -> result/flags stable, in_ready=0; a request presented meanwhile is not accepted until out_ready=1.
REQ-039 Assert reset for 1 cycle at the 4th cycle of MUL -> next cycle out_valid=0, in_ready=1, all outputs 0; no stale result appears.
REQ-040 Stream 4 ADDs back-to-back with out_ready=1 -> 4 consecutive out_valid cycles with correct results; without ALU_MUL_EN, a MUL in the stream gives err=1, result=0.

Source files
------------

// File: rtl/alu_pipe.sv
// alu_pipe: single-issue ALU (ADD/SUB/AND/OR/XOR/SHL/SHR/MUL) with valid/ready handshake and registered flags.
// Latency: 1 cycle for every op; MUL takes WIDTH+1 cycles when built with ALU_MUL_EN.
// Backpressure: result and flags hold while out_ready=0; in_ready drops during MUL and while a held result is not consumed.
// Build option: define ALU_MUL_EN to include the iterative shift-add multiplier; otherwise MUL completes at once with err=1.
module alu_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             err
);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SHL = 3'd5;
  localparam logic [2:0] OP_SHR = 3'd6;
  localparam logic [2:0] OP_MUL = 3'd7;

  // Shift amounts at or beyond this value flush the operand to zero.
  localparam logic [WIDTH:0] WIDTH_EXT = (WIDTH+1)'(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1
`ifdef ALU_MUL_EN
    ,
    MUL  = 2'd2
`endif
  } stateT;

  stateT            state;
  stateT            nextState;
  stateT            acceptState;
  logic             accept;
  logic             mulReq;
  logic             bigShift;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] aluRes;
  logic             aluCarry;
  logic             aluErr;

  assign in_ready  = (state == IDLE) || ((state == HOLD) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == HOLD);
  assign bigShift  = ({1'b0, opb} >= WIDTH_EXT);

`ifdef ALU_MUL_EN
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prodNext;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      mulCnt;
  logic               mulLast;

  assign mulReq      = (op == OP_MUL);
  assign acceptState = mulReq ? MUL : HOLD;
  assign mulLast     = (mulCnt == CW'(WIDTH-1));

  // One shift-add step: add the shifted multiplicand when the current multiplier bit is set.
  always_comb begin
    prodNext = prod;
    if (mplier[0]) prodNext = prod + mcand;
  end
`else
  assign mulReq      = 1'b0;
  assign acceptState = HOLD;
`endif

  // Single-cycle ops; MUL lands in the default arm, which flags it unsupported when no multiplier is built.
  always_comb begin
    aluRes   = '0;
    aluCarry = 1'b0;
    aluErr   = 1'b0;
    sum      = '0;
    case (op)
      OP_ADD: begin
        sum      = {1'b0, opa} + {1'b0, opb};
        aluRes   = sum[WIDTH-1:0];
        aluCarry = sum[WIDTH];
      end
      OP_SUB: begin
        aluRes   = opa - opb;
        aluCarry = (opa < opb);
      end
      OP_AND:  aluRes = opa & opb;
      OP_OR:   aluRes = opa | opb;
      OP_XOR:  aluRes = opa ^ opb;
      OP_SHL:  aluRes = bigShift ? '0 : (opa << opb);
      OP_SHR:  aluRes = bigShift ? '0 : (opa >> opb);
      default: aluErr = 1'b1;
    endcase
  end

  // Next-state: accept from IDLE, replace or drain from HOLD, leave MUL after the last step.
  always_comb begin
    nextState = state;
    case (state)
      IDLE: if (accept) nextState = acceptState;
      HOLD: if (out_ready) nextState = in_valid ? acceptState : IDLE;
`ifdef ALU_MUL_EN
      MUL:  if (mulLast) nextState = HOLD;
`endif
      default: nextState = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  // Result/flag registers and multiplier datapath; reset wins over any acceptance at the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      result <= '0;
      carry  <= 1'b0;
      zero   <= 1'b0;
      err    <= 1'b0;
`ifdef ALU_MUL_EN
      mcand  <= '0;
      prod   <= '0;
      mplier <= '0;
      mulCnt <= '0;
`endif
    end else begin
      if (accept && !mulReq) begin
        result <= aluRes;
        carry  <= aluCarry;
        zero   <= (aluRes == '0);
        err    <= aluErr;
      end
`ifdef ALU_MUL_EN
      if (accept && mulReq) begin
        mcand  <= {{WIDTH{1'b0}}, opa};
        mplier <= opb;
        prod   <= '0;
        mulCnt <= '0;
      end else if (state == MUL) begin
        prod   <= prodNext;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        mulCnt <= mulCnt + 1'b1;
        if (mulLast) begin
          result <= prodNext[WIDTH-1:0];
          carry  <= |prodNext[2*WIDTH-1:WIDTH];
          zero   <= (prodNext[WIDTH-1:0] == '0);
          err    <= 1'b0;
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: scoreboard bench for alu_pipe with a plain-arithmetic reference model.
// Driver pushes the expected response at each handshake; a negedge monitor compares whatever the DUT presents.
// Covers reset values, directed corner ops, backpressure, back-to-back streaming, mid-op reset, randomized traffic.
module tb_alu_pipe;
  localparam int W = 8;
`ifdef ALU_MUL_EN
  localparam int MUL_LAT = W + 1;
  localparam bit MUL_ON  = 1'b1;
`else
  localparam int MUL_LAT = 1;
  localparam bit MUL_ON  = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [2:0]   op = 3'd0;
  logic [W-1:0] opa = '0;
  logic [W-1:0] opb = '0;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         carry;
  logic         zero;
  logic         err;

  typedef struct {
    logic [W-1:0] res;
    logic         c;
    logic         z;
    logic         e;
    int           due;
    bit           seen;
  } expT;

  expT  q[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   lastAcc = 0;
  bit   randReady = 1'b0;
  logic manualReady = 1'b1;
  bit   monOn = 1'b0;

  alu_pipe #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .opa(opa), .opb(opb), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .carry(carry), .zero(zero), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Consumer: random or manually steered ready, updated a little after each rising edge.
  always @(posedge clk) begin
    #2;
    out_ready = randReady ? ($urandom_range(0, 3) != 0) : manualReady;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model: straight arithmetic on the unsigned operand values.
  function automatic expT model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    expT x;
    longint unsigned ua, ub, m, r;
    ua = longint'(a);
    ub = longint'(b);
    m  = longint'(1) << W;
    r  = 0;
    x.c = 1'b0;
    x.e = 1'b0;
    case (o)
      3'd0: begin r = ua + ub; x.c = (r >= m); end
      3'd1: begin r = ua + m - ub; x.c = (ua < ub); end
      3'd2: r = ua & ub;
      3'd3: r = ua | ub;
      3'd4: r = ua ^ ub;
      3'd5: r = (ub >= W) ? 0 : ua * (longint'(1) << ub);
      3'd6: r = (ub >= W) ? 0 : ua / (longint'(1) << ub);
      default: begin
        if (MUL_ON) begin r = ua * ub; x.c = (r >= m); end
        else        begin r = 0; x.e = 1'b1; end
      end
    endcase
    r = r % m;
    x.res  = r[W-1:0];
    x.z    = (r == 0);
    x.due  = 0;
    x.seen = 1'b0;
    return x;
  endfunction

  // Present one request and wait (bounded) for the handshake; the expectation is queued just before the accepting edge.
  task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    expT e;
    bit  done;
    int  n;
    in_valid = 1'b1;
    op  = o;
    opa = a;
    opb = b;
    done = 1'b0;
    n = 0;
    while (!done) begin
      @(negedge clk);
      if (in_ready === 1'b1 && !reset) begin
        e = model(o, a, b);
        e.due = cyc + ((o == 3'd7) ? MUL_LAT : 1);
        q.push_back(e);
        lastAcc = cyc;
        done = 1'b1;
      end else begin
        n++;
        if (n > 100) begin
          checks++;
          failures++;
          $display("FAIL issue_timeout actual=in_ready_low required=accept op=%0d", o);
          done = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: every presented result must match the head of the scoreboard, on time and stable while held.
  always @(negedge clk) begin
    if (monOn && !reset) begin
      if (out_valid === 1'b1) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL stale_result actual=out_valid=1 required=no_pending_op (cycle %0d)", cyc);
        end else begin
          chk("result", 64'(result), 64'(q[0].res));
          chk("carry", 64'(carry), 64'(q[0].c));
          chk("zero", 64'(zero), 64'(q[0].z));
          chk("err", 64'(err), 64'(q[0].e));
          if (!q[0].seen) begin
            chk("latency", 64'(cyc), 64'(q[0].due));
            q[0].seen = 1'b1;
          end
          if (out_ready === 1'b1) void'(q.pop_front());
        end
      end else if (q.size() != 0 && cyc >= q[0].due) begin
        checks++;
        failures++;
        $display("FAIL late_result actual=out_valid=%b required=1 (cycle %0d)", out_valid, cyc);
        void'(q.pop_front());
      end
    end
  end

  initial begin
    int prevAcc;
    logic [2:0]   ro;
    logic [W-1:0] ra, rb;

    // Reset values.
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    monOn = 1'b1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_carry", 64'(carry), 64'd0);
    chk("rst_zero", 64'(zero), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    @(posedge clk);
    #1;

    // Directed corner cases: ADD wrap, SUB borrow, SHL beyond width.
    issue(3'd0, 8'hFF, 8'h01);
    issue(3'd1, 8'h03, 8'h05);
    issue(3'd5, 8'h81, 8'h09);
    issue(3'd6, 8'h81, 8'h07);
    issue(3'd5, 8'h81, 8'h07);
    issue(3'd6, 8'h80, 8'h08);
    idle(2);

    // Multiplier: busy for WIDTH cycles, then overflow case.
    issue(3'd7, 8'h0F, 8'h11);
    if (MUL_ON) begin
      repeat (W) begin
        @(negedge clk);
        chk("mul_busy_in_ready", 64'(in_ready), 64'd0);
      end
      @(posedge clk);
      #1;
    end
    issue(3'd7, 8'h10, 8'h10);
    idle(MUL_LAT + 2);

    // Backpressure: result held 3 cycles, a pending request waits for out_ready.
    manualReady = 1'b0;
    issue(3'd0, 8'h5A, 8'h33);
    fork
      issue(3'd4, 8'hF0, 8'h3C);
      begin
        repeat (3) begin
          @(negedge clk);
          chk("held_in_ready", 64'(in_ready), 64'd0);
        end
        manualReady = 1'b1;
      end
    join
    idle(2);

    // Back-to-back stream; the middle slot is a MUL when no multiplier is built.
    prevAcc = 0;
    for (int i = 0; i < 5; i++) begin
      ro = (i == 2 && !MUL_ON) ? 3'd7 : 3'd0;
      issue(ro, W'(8'h40 * i + 8'h11), W'(8'hC0 + i));
      if (i > 0) chk("b2b_accept", 64'(lastAcc), 64'(prevAcc + 1));
      prevAcc = lastAcc;
    end
    idle(3);

    // Reset in the 4th cycle of an in-flight MUL discards it.
    manualReady = 1'b0;
    issue(3'd7, 8'h0F, 8'h11);
    repeat (3) begin
      @(posedge clk);
    end
    #1;
    reset = 1'b1;
    q.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    manualReady = 1'b1;
    @(negedge clk);
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
    chk("mid_rst_result", 64'(result), 64'd0);
    chk("mid_rst_carry", 64'(carry), 64'd0);
    chk("mid_rst_zero", 64'(zero), 64'd0);
    chk("mid_rst_err", 64'(err), 64'd0);
    @(posedge clk);
    #1;
    idle(W + 4);

    // Randomized traffic with random consumer backpressure.
    randReady = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      ro = 3'($urandom_range(0, 7));
      ra = W'($urandom);
      rb = W'($urandom);
      if (ro == 3'd5 || ro == 3'd6) rb = W'($urandom_range(0, W + 3));
      if ($urandom_range(0, 7) == 0) ra = '1;
      if ($urandom_range(0, 7) == 0) rb = '0;
      issue(ro, ra, rb);
    end

    // Drain outstanding results.
    randReady = 1'b0;
    manualReady = 1'b1;
    in_valid = 1'b0;
    for (int i = 0; i < 200 && q.size() != 0; i++) @(negedge clk);
    chk("drain_empty", 64'(q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
